// File: rtl/ama_serial_add_ctrl.sv
// ama_serial_add_ctrl
//   Sequences one WIDTH-bit addition as NSLICE carry-chained beats through a
//   single external SLICE-bit approximate-adder slice. The lowest `appr`
//   slices of each operation run in approximate mode and the rest run exact.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand request handshake
//   in_a, in_b, in_cin         operands and carry-in
//   in_appr                    number of low slices run approximate (clamped to NSLICE)
//   out_valid/out_ready        result handshake
//   out_s, out_cout            sum and final carry-out
//   slice_a, slice_b           operand bytes driven to the external slice
//   slice_cin, slice_appr_en   carry and mode driven to the external slice
//   slice_s, slice_cout        combinational slice results
//   busy                       operation in flight (state is not idle)
//   op_count                   completed operations, saturating
module ama_serial_add_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [2:0]       in_appr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic [SLICE-1:0] slice_a,
  output logic [SLICE-1:0] slice_b,
  output logic             slice_cin,
  output logic             slice_appr_en,
  input  logic [SLICE-1:0] slice_s,
  input  logic             slice_cout,
  output logic             busy,
  output logic [CNTW-1:0]  op_count
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  // Wide enough for both the 3-bit request and the value NSLICE itself.
  localparam int unsigned AW     = ($clog2(NSLICE + 1) > 3) ? $clog2(NSLICE + 1) : 3;

  localparam logic [IW-1:0] LastIdx = IW'(NSLICE - 1);
  localparam logic [AW-1:0] ApprMax = AW'(NSLICE);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                        state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic                          carry_q, carry_d;
  logic [NSLICE-1:0][SLICE-1:0]  a_q, a_d;
  logic [NSLICE-1:0][SLICE-1:0]  b_q, b_d;
  logic                          cin_q, cin_d;
  logic [AW-1:0]                 appr_q, appr_d;
  logic [NSLICE-1:0][SLICE-1:0]  sum_q, sum_d;
  logic                          cout_q, cout_d;
  logic [CNTW-1:0]               cnt_q, cnt_d;

  logic [AW-1:0]                 appr_req;
  logic [AW-1:0]                 appr_clamped;

  assign appr_req     = AW'(in_appr);
  assign appr_clamped = (appr_req > ApprMax) ? ApprMax : appr_req;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    carry_d       = carry_q;
    a_d           = a_q;
    b_d           = b_q;
    cin_d         = cin_q;
    appr_d        = appr_q;
    sum_d         = sum_q;
    cout_d        = cout_q;
    cnt_d         = cnt_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    slice_a       = '0;
    slice_b       = '0;
    slice_cin     = 1'b0;
    slice_appr_en = 1'b0;

    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          appr_d  = appr_clamped;
          idx_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        slice_a       = a_q[idx_q];
        slice_b       = b_q[idx_q];
        slice_cin     = (idx_q == '0) ? cin_q : carry_q;
        slice_appr_en = (AW'(idx_q) < appr_q);
        sum_d[idx_q]  = slice_s;
        carry_d       = slice_cout;
        idx_d         = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = StDone;
        end
      end

      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      appr_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      appr_q  <= appr_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_s    = sum_q;
  assign out_cout = cout_q;
  assign busy     = (state_q != StIdle);
  assign op_count = cnt_q;

endmodule
